dbus_bridge: RTL and testbench

Parametrised data-bus interface between the core's load/store unit and the AHB-lite-like system bus. It adds the following to the previous generation:
- a valid/ready request handshake with a request queue;
- configurable data width;
- byte-lane extraction and sign extension of load data;
- write-lane replication;
- alignment checking without a bus access;
- a data-phase timeout.

Responses return strictly in request order. At most one bus transfer is in its data phase at any time.

---
 rtl/dbus_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_dbus_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_bridge.sv
// Load/store-unit to AHB-lite-like bus bridge: request queue, single outstanding
// data phase, byte-lane handling, alignment checking and optional data-phase timeout.
module dbus_bridge #(
  parameter int DW      = 32,
  parameter int QDEPTH  = 2,
  parameter int TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic          req_w_rb,
  input  logic [1:0]    req_size,
  input  logic          req_sext,
  input  logic [31:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_vld,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          bus_hung,
  output logic [31:0]   haddr,
  output logic          hprot,
  output logic [1:0]    hsize,
  output logic          hwrite,
  output logic [DW-1:0] hwdata,
  output logic          htrans,
  input  logic [DW-1:0] hrdata,
  input  logic          hresp,
  input  logic          hready
);

  localparam int OW = $clog2(DW / 8);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // A dword access on a 32-bit bus is treated like a misaligned one: error, no bus access.
  function automatic logic is_bad(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = addr[0];
      2'd2:    bad = |addr[1:0];
      default: bad = (|addr[2:0]) | (DW != 64);
    endcase
    return bad;
  endfunction

  function automatic logic [DW-1:0] replicate(input logic [1:0] size, input logic [DW-1:0] wd);
    logic [DW-1:0] r;
    case (size)
      2'd0:    r = {(DW / 8){wd[7:0]}};
      2'd1:    r = {(DW / 16){wd[15:0]}};
      2'd2:    r = {(DW / 32){wd[31:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] extend(input logic [DW-1:0] raw, input logic [1:0] size,
                                           input logic sext, input logic [OW-1:0] off);
    logic [DW-1:0] sh;
    logic [DW-1:0] r;
    sh = raw >> {off, 3'b000};
    case (size)
      2'd0:    r = sext ? DW'(signed'(sh[7:0]))  : DW'(sh[7:0]);
      2'd1:    r = sext ? DW'(signed'(sh[15:0])) : DW'(sh[15:0]);
      2'd2:    r = sext ? DW'(signed'(sh[31:0])) : DW'(sh[31:0]);
      default: r = sh;
    endcase
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic          q_wrb_q   [QDEPTH];
  logic [1:0]    q_size_q  [QDEPTH];
  logic          q_sext_q  [QDEPTH];
  logic [31:0]   q_addr_q  [QDEPTH];
  logic [DW-1:0] q_wdata_q [QDEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          dp_vld_q, dp_vld_d;
  logic          dp_wrb_q, dp_wrb_d;
  logic [1:0]    dp_size_q, dp_size_d;
  logic          dp_sext_q, dp_sext_d;
  logic [OW-1:0] dp_off_q, dp_off_d;
  logic [DW-1:0] dp_wdata_q, dp_wdata_d;

  logic          mis_rsp_q, mis_rsp_d;
  logic          hung_q, hung_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic empty_s, full_s, head_bad_s, enq_s, deq_s, issue_s, drop_s, dp_done_s, tmo_hit_s;

  assign empty_s    = (cnt_q == '0);
  assign full_s     = (cnt_q == CW'(QDEPTH));
  assign head_bad_s = is_bad(q_size_q[rd_ptr_q], q_addr_q[rd_ptr_q]);
  assign tmo_hit_s  = (TIMEOUT > 0) && dp_vld_q && (tmo_q == TW'(TIMEOUT));
  assign dp_done_s  = dp_vld_q & hready & ~tmo_hit_s;

  assign htrans     = ~empty_s & ~head_bad_s & ~hung_q;
  assign issue_s    = htrans & (~dp_vld_q | dp_done_s);
  // Misaligned heads wait for the bus to go idle so their error stays in order.
  assign drop_s     = ~empty_s & head_bad_s & ~dp_vld_q;
  assign deq_s      = issue_s | drop_s;
  assign enq_s      = req_vld & ~full_s;

  assign req_rdy  = ~full_s;
  assign haddr    = q_addr_q[rd_ptr_q];
  assign hsize    = q_size_q[rd_ptr_q];
  assign hwrite   = q_wrb_q[rd_ptr_q];
  assign hprot    = 1'b1;
  assign hwdata   = dp_wdata_q;
  assign bus_hung = hung_q;

  // Queue storage write port.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      q_wrb_q[wr_ptr_q]   <= req_w_rb;
      q_size_q[wr_ptr_q]  <= req_size;
      q_sext_q[wr_ptr_q]  <= req_sext;
      q_addr_q[wr_ptr_q]  <= req_addr;
      q_wdata_q[wr_ptr_q] <= req_wdata;
    end
  end

  // Queue pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = enq_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = deq_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq_s && !deq_s) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!enq_s && deq_s) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Data-phase register, misalign response, timeout and hung-flag next state.
  always_comb begin
    dp_vld_d   = dp_vld_q;
    dp_wrb_d   = dp_wrb_q;
    dp_size_d  = dp_size_q;
    dp_sext_d  = dp_sext_q;
    dp_off_d   = dp_off_q;
    dp_wdata_d = dp_wdata_q;
    if (issue_s) begin
      dp_vld_d   = 1'b1;
      dp_wrb_d   = q_wrb_q[rd_ptr_q];
      dp_size_d  = q_size_q[rd_ptr_q];
      dp_sext_d  = q_sext_q[rd_ptr_q];
      dp_off_d   = q_addr_q[rd_ptr_q][OW-1:0];
      dp_wdata_d = replicate(q_size_q[rd_ptr_q], q_wdata_q[rd_ptr_q]);
    end else if (dp_done_s || tmo_hit_s) begin
      dp_vld_d = 1'b0;
    end else begin
      dp_vld_d = dp_vld_q;
    end
    mis_rsp_d = drop_s;
    hung_d    = hung_q | tmo_hit_s;
    if ((TIMEOUT > 0) && dp_vld_q && !hready && !tmo_hit_s) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      dp_vld_q   <= 1'b0;
      dp_wrb_q   <= 1'b0;
      dp_size_q  <= 2'd0;
      dp_sext_q  <= 1'b0;
      dp_off_q   <= '0;
      dp_wdata_q <= '0;
      mis_rsp_q  <= 1'b0;
      hung_q     <= 1'b0;
      tmo_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      dp_vld_q   <= dp_vld_d;
      dp_wrb_q   <= dp_wrb_d;
      dp_size_q  <= dp_size_d;
      dp_sext_q  <= dp_sext_d;
      dp_off_q   <= dp_off_d;
      dp_wdata_q <= dp_wdata_d;
      mis_rsp_q  <= mis_rsp_d;
      hung_q     <= hung_d;
      tmo_q      <= tmo_d;
    end
  end

  // Response mux; bus completions are combinational from hready.
  always_comb begin
    rsp_vld  = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;
    if (mis_rsp_q || tmo_hit_s) begin
      rsp_vld = 1'b1;
      rsp_err = 1'b1;
    end else if (dp_vld_q && hready) begin
      rsp_vld  = 1'b1;
      rsp_err  = hresp;
      rsp_data = dp_wrb_q ? '0 : extend(hrdata, dp_size_q, dp_sext_q, dp_off_q);
    end else begin
      rsp_vld = 1'b0;
    end
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed self-checking bench for dbus_bridge (DW=32, QDEPTH=2, TIMEOUT=4).
module tb_dbus_bridge;

  logic        clk, rst;
  logic        req_vld, req_rdy, req_w_rb, req_sext;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_vld, rsp_err, bus_hung;
  logic [31:0] rsp_data;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hprot, hwrite, htrans, hresp, hready;
  logic [1:0]  hsize;

  int checks = 0;
  int errors = 0;

  dbus_bridge #(.DW(32), .QDEPTH(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_w_rb(req_w_rb), .req_size(req_size),
    .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err), .bus_hung(bus_hung),
    .haddr(haddr), .hprot(hprot), .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
    .htrans(htrans), .hrdata(hrdata), .hresp(hresp), .hready(hready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL reset_req_rdy: got %b exp 1", req_rdy); end
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld: got %b exp 0", rsp_vld); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b exp 0", rsp_err); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h exp 0", rsp_data); end
    checks++; if (bus_hung !== 1'b0) begin errors++; $display("FAIL reset_bus_hung: got %b exp 0", bus_hung); end
    checks++; if (htrans !== 1'b0) begin errors++; $display("FAIL reset_htrans: got %b exp 0", htrans); end
    checks++; if (hwdata !== 32'h0) begin errors++; $display("FAIL reset_hwdata: got %h exp 0", hwdata); end
    checks++; if (hprot !== 1'b1) begin errors++; $display("FAIL reset_hprot: got %b exp 1", hprot); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word_read();
    @(negedge clk);
    req_vld = 1'b1; req_w_rb = 1'b0; req_size = 2'd2; req_sext = 1'b0; req_addr = 32'h1000;
    hready = 1'b1; hrdata = 32'hDEADBEEF;
    #1;
    checks++; if (htrans !== 1'b0) begin errors++; $display("FAIL wr_n_htrans: got %b exp 0", htrans); end
    @(negedge clk);
    req_vld = 1'b0;
    #1;
    checks++; if (htrans !== 1'b1) begin errors++; $display("FAIL rd_n1_htrans: got %b exp 1", htrans); end
    checks++; if (haddr !== 32'h1000) begin errors++; $display("FAIL rd_n1_haddr: got %h exp 1000", haddr); end
    checks++; if (hsize !== 2'd2 || hwrite !== 1'b0) begin errors++; $display("FAIL rd_n1_ctl: got size %0d write %b exp 2 0", hsize, hwrite); end
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL rd_n1_rsp_vld: got %b exp 0", rsp_vld); end
    @(negedge clk);
    #1;
    checks++; if (rsp_vld !== 1'b1) begin errors++; $display("FAIL rd_n2_rsp_vld: got %b exp 1", rsp_vld); end
    checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_n2_rsp_data: got %h exp deadbeef", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rd_n2_rsp_err: got %b exp 0", rsp_err); end
    @(negedge clk);
    #1;
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL rd_n3_rsp_vld: got %b exp 0", rsp_vld); end
  endtask

  task automatic test_lanes();
    logic [31:0] va[5], vd[5], vx[5];
    logic [1:0]  vs[5];
    logic        vse[5], vr[5];
    va[0] = 32'h1003; vs[0] = 2'd0; vse[0] = 1'b1; vd[0] = 32'h80123456; vr[0] = 1'b0; vx[0] = 32'hFFFFFF80;
    va[1] = 32'h1003; vs[1] = 2'd0; vse[1] = 1'b0; vd[1] = 32'h80123456; vr[1] = 1'b0; vx[1] = 32'h00000080;
    va[2] = 32'h1002; vs[2] = 2'd1; vse[2] = 1'b1; vd[2] = 32'h80F01234; vr[2] = 1'b0; vx[2] = 32'hFFFF80F0;
    va[3] = 32'h1001; vs[3] = 2'd0; vse[3] = 1'b1; vd[3] = 32'h00007F00; vr[3] = 1'b0; vx[3] = 32'h0000007F;
    va[4] = 32'h1004; vs[4] = 2'd2; vse[4] = 1'b0; vd[4] = 32'h12345678; vr[4] = 1'b1; vx[4] = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_vld = 1'b1; req_w_rb = 1'b0; req_size = vs[i]; req_sext = vse[i]; req_addr = va[i];
      hready = 1'b1; hrdata = vd[i]; hresp = vr[i];
      @(negedge clk);
      req_vld = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (rsp_vld !== 1'b1) begin errors++; $display("FAIL lane%0d_rsp_vld: got %b exp 1", i, rsp_vld); end
      checks++; if (rsp_data !== vx[i]) begin errors++; $display("FAIL lane%0d_rsp_data: got %h exp %h", i, rsp_data, vx[i]); end
      checks++; if (rsp_err !== vr[i]) begin errors++; $display("FAIL lane%0d_rsp_err: got %b exp %b", i, rsp_err, vr[i]); end
    end
    @(negedge clk);
    hresp = 1'b0;
  endtask

  task automatic test_write_repl();
    logic [31:0] wa[2], wd[2], wx[2];
    logic [1:0]  ws[2];
    wa[0] = 32'h2002; ws[0] = 2'd1; wd[0] = 32'hABCD1234; wx[0] = 32'h12341234;
    wa[1] = 32'h2001; ws[1] = 2'd0; wd[1] = 32'h000000A5; wx[1] = 32'hA5A5A5A5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_vld = 1'b1; req_w_rb = 1'b1; req_size = ws[i]; req_sext = 1'b0; req_addr = wa[i];
      req_wdata = wd[i]; hready = 1'b1;
      @(negedge clk);
      req_vld = 1'b0;
      #1;
      checks++; if (htrans !== 1'b1 || hwrite !== 1'b1 || hsize !== ws[i]) begin errors++; $display("FAIL wr%0d_addr_phase: got htrans %b hwrite %b hsize %0d exp 1 1 %0d", i, htrans, hwrite, hsize, ws[i]); end
      @(negedge clk);
      #1;
      checks++; if (hwdata !== wx[i]) begin errors++; $display("FAIL wr%0d_hwdata: got %h exp %h", i, hwdata, wx[i]); end
      checks++; if (rsp_vld !== 1'b1 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL wr%0d_rsp: got vld %b data %h err %b exp 1 0 0", i, rsp_vld, rsp_data, rsp_err); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ba[3], bd[3], bx[3];
    logic [1:0]  bs[3];
    ba[0] = 32'h3000; bs[0] = 2'd2; bd[0] = 32'h11111111; bx[0] = 32'h11111111;
    ba[1] = 32'h3001; bs[1] = 2'd0; bd[1] = 32'h00000022; bx[1] = 32'h22222222;
    ba[2] = 32'h3002; bs[2] = 2'd1; bd[2] = 32'h00003333; bx[2] = 32'h33333333;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      hready = 1'b1;
      if (c < 3) begin
        req_vld = 1'b1; req_w_rb = 1'b1; req_size = bs[c]; req_addr = ba[c]; req_wdata = bd[c];
      end else begin
        req_vld = 1'b0;
      end
      #1;
      if (c < 3) begin
        checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL b2b_c%0d_req_rdy: got %b exp 1", c, req_rdy); end
      end
      if (c >= 1 && c <= 3) begin
        checks++; if (htrans !== 1'b1 || haddr !== ba[c-1]) begin errors++; $display("FAIL b2b_c%0d_addr: got htrans %b haddr %h exp 1 %h", c, htrans, haddr, ba[c-1]); end
      end
      if (c >= 2 && c <= 4) begin
        checks++; if (rsp_vld !== 1'b1 || hwdata !== bx[c-2]) begin errors++; $display("FAIL b2b_c%0d_data: got vld %b hwdata %h exp 1 %h", c, rsp_vld, hwdata, bx[c-2]); end
      end
      if (c == 5) begin
        checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL b2b_idle_rsp_vld: got %b exp 0", rsp_vld); end
      end
    end
  endtask

  task automatic test_queue_full();
    @(negedge clk);
    req_vld = 1'b1; req_w_rb = 1'b0; req_size = 2'd2; req_sext = 1'b0; req_addr = 32'h4000; hready = 1'b1;
    @(negedge clk);
    req_addr = 32'h4004; hready = 1'b0;
    #1;
    checks++; if (htrans !== 1'b1 || haddr !== 32'h4000) begin errors++; $display("FAIL qf_c1_addr: got htrans %b haddr %h exp 1 4000", htrans, haddr); end
    @(negedge clk);
    req_addr = 32'h4008;
    #1;
    checks++; if (rsp_vld !== 1'b0 || haddr !== 32'h4004 || req_rdy !== 1'b1) begin errors++; $display("FAIL qf_c2: got vld %b haddr %h rdy %b exp 0 4004 1", rsp_vld, haddr, req_rdy); end
    @(negedge clk);
    req_addr = 32'h400C;
    #1;
    checks++; if (req_rdy !== 1'b0) begin errors++; $display("FAIL qf_full_req_rdy: got %b exp 0", req_rdy); end
    checks++; if (rsp_vld !== 1'b0 || haddr !== 32'h4004) begin errors++; $display("FAIL qf_c3_hold: got vld %b haddr %h exp 0 4004", rsp_vld, haddr); end
    @(negedge clk);
    hready = 1'b1; hrdata = 32'hAAAA0001;
    #1;
    checks++; if (rsp_vld !== 1'b1 || rsp_data !== 32'hAAAA0001 || req_rdy !== 1'b0) begin errors++; $display("FAIL qf_rsp_a: got vld %b data %h rdy %b exp 1 aaaa0001 0", rsp_vld, rsp_data, req_rdy); end
    @(negedge clk);
    hrdata = 32'hBBBB0002;
    #1;
    checks++; if (rsp_vld !== 1'b1 || rsp_data !== 32'hBBBB0002) begin errors++; $display("FAIL qf_rsp_b: got vld %b data %h exp 1 bbbb0002", rsp_vld, rsp_data); end
    checks++; if (req_rdy !== 1'b1 || haddr !== 32'h4008) begin errors++; $display("FAIL qf_c5_enq_deq: got rdy %b haddr %h exp 1 4008", req_rdy, haddr); end
    @(negedge clk);
    req_vld = 1'b0; hrdata = 32'hCCCC0003;
    #1;
    checks++; if (rsp_vld !== 1'b1 || rsp_data !== 32'hCCCC0003) begin errors++; $display("FAIL qf_rsp_c: got vld %b data %h exp 1 cccc0003", rsp_vld, rsp_data); end
    checks++; if (htrans !== 1'b1 || haddr !== 32'h400C) begin errors++; $display("FAIL qf_c6_addr: got htrans %b haddr %h exp 1 400c", htrans, haddr); end
    @(negedge clk);
    hrdata = 32'hDDDD0004;
    #1;
    checks++; if (rsp_vld !== 1'b1 || rsp_data !== 32'hDDDD0004 || htrans !== 1'b0) begin errors++; $display("FAIL qf_rsp_d: got vld %b data %h htrans %b exp 1 dddd0004 0", rsp_vld, rsp_data, htrans); end
    @(negedge clk);
    #1;
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL qf_idle_rsp_vld: got %b exp 0", rsp_vld); end
  endtask

  task automatic test_misaligned();
    logic [31:0] ma[3], hd[7], ed[7], eaddr[7];
    logic        et[7], ev[7], ee[7];
    ma[0] = 32'h1000; ma[1] = 32'h1002; ma[2] = 32'h1008;
    for (int c = 0; c < 7; c++) begin
      hd[c] = 32'h0A000000 + 32'(c); et[c] = 1'b0; ev[c] = 1'b0; ee[c] = 1'b0; ed[c] = 32'h0; eaddr[c] = 32'h0;
    end
    et[1] = 1'b1; eaddr[1] = 32'h1000;
    ev[2] = 1'b1; ed[2] = 32'h0A000002;
    et[4] = 1'b1; eaddr[4] = 32'h1008; ev[4] = 1'b1; ee[4] = 1'b1;
    ev[5] = 1'b1; ed[5] = 32'h0A000005;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      hready = 1'b1; hrdata = hd[c];
      if (c < 3) begin
        req_vld = 1'b1; req_w_rb = 1'b0; req_size = 2'd2; req_sext = 1'b0; req_addr = ma[c];
      end else begin
        req_vld = 1'b0;
      end
      #1;
      checks++; if (htrans !== et[c]) begin errors++; $display("FAIL mis_c%0d_htrans: got %b exp %b", c, htrans, et[c]); end
      if (et[c]) begin
        checks++; if (haddr !== eaddr[c]) begin errors++; $display("FAIL mis_c%0d_haddr: got %h exp %h", c, haddr, eaddr[c]); end
      end
      checks++; if (rsp_vld !== ev[c] || rsp_err !== ee[c]) begin errors++; $display("FAIL mis_c%0d_rsp: got vld %b err %b exp %b %b", c, rsp_vld, rsp_err, ev[c], ee[c]); end
      if (ev[c]) begin
        checks++; if (rsp_data !== ed[c]) begin errors++; $display("FAIL mis_c%0d_data: got %h exp %h", c, rsp_data, ed[c]); end
      end
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    req_vld = 1'b1; req_w_rb = 1'b0; req_size = 2'd2; req_sext = 1'b0; req_addr = 32'h5000; hready = 1'b1;
    @(negedge clk);
    req_vld = 1'b0; hready = 1'b0;
    #1;
    checks++; if (htrans !== 1'b1) begin errors++; $display("FAIL to_issue_htrans: got %b exp 1", htrans); end
    @(negedge clk);
    req_vld = 1'b1; req_addr = 32'h5004;
    #1;
    checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL to_wait0_rsp_vld: got %b exp 0", rsp_vld); end
    for (int w = 1; w < 4; w++) begin
      @(negedge clk);
      req_vld = 1'b0;
      #1;
      checks++; if (rsp_vld !== 1'b0 || bus_hung !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got vld %b hung %b exp 0 0", w, rsp_vld, bus_hung); end
    end
    @(negedge clk);
    #1;
    checks++; if (rsp_vld !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin errors++; $display("FAIL to_abort_rsp: got vld %b err %b data %h exp 1 1 0", rsp_vld, rsp_err, rsp_data); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      hready = 1'b1;
      #1;
      checks++; if (htrans !== 1'b0 || bus_hung !== 1'b1 || rsp_vld !== 1'b0) begin errors++; $display("FAIL to_hung%0d: got htrans %b hung %b vld %b exp 0 1 0", k, htrans, bus_hung, rsp_vld); end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus_hung !== 1'b0 || htrans !== 1'b0 || req_rdy !== 1'b1) begin errors++; $display("FAIL to_rst_flush: got hung %b htrans %b rdy %b exp 0 0 1", bus_hung, htrans, req_rdy); end
    @(negedge clk);
    rst = 1'b0; req_vld = 1'b1; req_addr = 32'h6000; hrdata = 32'h600D600D;
    @(negedge clk);
    req_vld = 1'b0;
    #1;
    checks++; if (htrans !== 1'b1 || haddr !== 32'h6000) begin errors++; $display("FAIL to_recover_addr: got htrans %b haddr %h exp 1 6000", htrans, haddr); end
    @(negedge clk);
    #1;
    checks++; if (rsp_vld !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h600D600D) begin errors++; $display("FAIL to_recover_rsp: got vld %b err %b data %h exp 1 0 600d600d", rsp_vld, rsp_err, rsp_data); end
  endtask

  initial begin
    rst = 1'b1; req_vld = 1'b0; req_w_rb = 1'b0; req_size = 2'd0; req_sext = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; hrdata = 32'h0; hresp = 1'b0; hready = 1'b1;
    test_reset();
    test_word_read();
    test_lanes();
    test_write_repl();
    test_back_to_back();
    test_queue_full();
    test_misaligned();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
